// File: rtl/imm_extender.sv
// Registered immediate generator: sign/zero/upper extension of a 16-bit field, 2:1 mux with alt, output register.
// Optional IMM_SHIFT2_EN adds a shift2 input that produces word-aligned branch offsets.

module imm_and_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

module imm_ext_unit (
  input  logic [15:0] imm,
  input  logic        sbit,
  input  logic        lui,
  input  logic        shift2,
  output logic [31:0] ext32
);
  // lui outranks shift2, which outranks plain extension
  always_comb begin
    ext32 = {{16{sbit}}, imm};
    if (lui) begin
      ext32 = {imm, 16'h0000};
    end else if (shift2) begin
      ext32 = {{14{sbit}}, imm, 2'b00};
    end
  end
endmodule

module imm_mux32 (
  input  logic        sel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  assign y = sel ? b : a;
endmodule

module imm_extender (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] imm,
  input  logic        ext,
  input  logic        lui,
`ifdef IMM_SHIFT2_EN
  input  logic        shift2,
`endif
  input  logic        sel,
  input  logic [31:0] alt,
  input  logic        in_valid,
  output logic [31:0] comb_out,
  output logic [31:0] out,
  output logic        out_valid
);
  // Handshake: in_valid qualifies the inputs; there is no ready. Every rising
  // edge with in_valid=1 and rst=0 captures comb_out into out and raises
  // out_valid for exactly that following cycle.

  logic        sbit;
  logic        shift2_int;
  logic [31:0] ext32;

`ifdef IMM_SHIFT2_EN
  assign shift2_int = shift2;
`else
  assign shift2_int = 1'b0;
`endif

  imm_and_gate u_and (
    .a (ext),
    .b (imm[15]),
    .y (sbit)
  );

  imm_ext_unit u_ext (
    .imm    (imm),
    .sbit   (sbit),
    .lui    (lui),
    .shift2 (shift2_int),
    .ext32  (ext32)
  );

  imm_mux32 u_mux (
    .sel (sel),
    .a   (ext32),
    .b   (alt),
    .y   (comb_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= 32'h0000_0000;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      out       <= comb_out;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_extender.sv
// Directed self-checking bench for imm_extender; shift2 cases compile in only with IMM_SHIFT2_EN.

module tb_imm_extender;

  logic        clk;
  logic        rst;
  logic [15:0] imm;
  logic        ext;
  logic        lui;
  logic        shift2;
  logic        sel;
  logic [31:0] alt;
  logic        in_valid;
  logic [31:0] comb_out;
  logic [31:0] out;
  logic        out_valid;

  int errors;
  int checks;
  logic [31:0] exp_q[$];

  imm_extender dut (
    .clk       (clk),
    .rst       (rst),
    .imm       (imm),
    .ext       (ext),
    .lui       (lui),
`ifdef IMM_SHIFT2_EN
    .shift2    (shift2),
`endif
    .sel       (sel),
    .alt       (alt),
    .in_valid  (in_valid),
    .comb_out  (comb_out),
    .out       (out),
    .out_valid (out_valid)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst      = 1'b1;
    imm      = 16'h0000;
    ext      = 1'b0;
    lui      = 1'b0;
    shift2   = 1'b0;
    sel      = 1'b0;
    alt      = 32'h0;
    in_valid = 1'b0;
  end

  // driver: apply a vector just after the falling edge, settle 1 time unit
  task automatic drive(input logic [15:0] i, input logic e, input logic l,
                       input logic s, input logic [31:0] a, input logic v);
    @(negedge clk);
    imm = i; ext = e; lui = l; sel = s; alt = a; in_valid = v;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(16'h1234, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (out !== 32'h0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: out=%h valid=%b expected out=00000000 valid=0", c, out, out_valid);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    checks++;
    if (out !== 32'h0000_1234 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: out=%h valid=%b expected out=00001234 valid=1", out, out_valid);
    end
  endtask

  task automatic test_extend();
    logic [15:0] v_imm [6] = '{16'hFFFC, 16'hFFFC, 16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF};
    logic        v_ext [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] v_exp [6] = '{32'hFFFF_FFFC, 32'h0000_FFFC, 32'hFFFF_8000,
                               32'h0000_8000, 32'h0000_7FFF, 32'h0000_7FFF};
    for (int i = 0; i < 6; i++) begin
      drive(v_imm[i], v_ext[i], 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1);
      checks++;
      if (comb_out !== v_exp[i]) begin
        errors++;
        $display("FAIL extend_comb[%0d]: comb_out=%h expected %h", i, comb_out, v_exp[i]);
      end
      step();
      checks++;
      if (out !== v_exp[i] || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL extend_reg[%0d]: out=%h valid=%b expected %h valid=1", i, out, out_valid, v_exp[i]);
      end
    end
  endtask

  task automatic test_lui();
    drive(16'hABCD, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    step();
    checks++;
    if (out !== 32'hABCD_0000) begin
      errors++;
      $display("FAIL lui_ext1: out=%h expected abcd0000", out);
    end
    drive(16'h8001, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if (comb_out !== 32'h8001_0000) begin
      errors++;
      $display("FAIL lui_ext0: comb_out=%h expected 80010000", comb_out);
    end
  endtask

  task automatic test_alt_hold();
    drive(16'h8000, 1'b1, 1'b0, 1'b1, 32'h0040_0020, 1'b1);
    checks++;
    if (comb_out !== 32'h0040_0020) begin
      errors++;
      $display("FAIL alt_comb: comb_out=%h expected 00400020", comb_out);
    end
    step();
    checks++;
    if (out !== 32'h0040_0020 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL alt_reg: out=%h valid=%b expected 00400020 valid=1", out, out_valid);
    end
    drive(16'h1111, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (out !== 32'h0040_0020 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL hold cyc%0d: out=%h valid=%b expected 00400020 valid=0", c, out, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v_imm [3] = '{16'h0001, 16'h8001, 16'h7FFF};
    logic [31:0] v_exp [3] = '{32'h0000_0001, 32'hFFFF_8001, 32'h0000_7FFF};
    logic [31:0] e;
    for (int i = 0; i < 3; i++) begin
      drive(v_imm[i], 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      exp_q.push_back(v_exp[i]);
      step();
      e = exp_q.pop_front();
      checks++;
      if (out !== e || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b[%0d]: out=%h valid=%b expected %h valid=1", i, out, out_valid, e);
      end
    end
  endtask

  task automatic test_reset_midstream();
    drive(16'h0055, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    rst = 1'b1;
    step();
    checks++;
    if (out !== 32'h0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: out=%h valid=%b expected 00000000 valid=0", out, out_valid);
    end
    drive(16'h00AA, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    rst = 1'b0;
    step();
    checks++;
    if (out !== 32'h0000_00AA || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_release: out=%h valid=%b expected 000000aa valid=1", out, out_valid);
    end
  endtask

`ifdef IMM_SHIFT2_EN
  task automatic test_shift2();
    logic [15:0] v_imm [4] = '{16'hFFFF, 16'h0001, 16'h8000, 16'h1234};
    logic        v_ext [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic        v_lui [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] v_exp [4] = '{32'hFFFF_FFFC, 32'h0000_0004, 32'h0002_0000, 32'h1234_0000};
    for (int i = 0; i < 4; i++) begin
      shift2 = 1'b1;
      drive(v_imm[i], v_ext[i], v_lui[i], 1'b0, 32'h0, 1'b1);
      step();
      checks++;
      if (out !== v_exp[i]) begin
        errors++;
        $display("FAIL shift2[%0d]: out=%h expected %h", i, out, v_exp[i]);
      end
    end
    shift2 = 1'b0;
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_extend();
    test_lui();
    test_alt_hold();
    test_back_to_back();
    test_reset_midstream();
`ifdef IMM_SHIFT2_EN
    test_shift2();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imm_extender.md
Name: imm_extender

Overview:
- Registered immediate-generation unit for the single-cycle/pipelined CPU datapath.
- Takes a 16-bit instruction immediate and extends it to 32 bits: sign-extend or zero-extend, or places it in the upper half for LUI.
- A 32-bit 2:1 mux then selects between the extended immediate and an alternate 32-bit source. The result is registered for the ALU/PC stage.
- Built structurally from an and-gate (sign-bit qualification), an extender, and a 32-bit 2:1 mux, with an output register.

Parameters:
- none. Widths are fixed: 16-bit immediate, 32-bit datapath.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- imm  input  16  raw immediate field
- ext  input  1  1 = sign-extend, 0 = zero-extend
- lui  input  1  1 = upper placement {imm, 16'h0000}; overrides ext
- sel  input  1  mux select: 0 = extended immediate, 1 = alt
- alt  input  32  alternate 32-bit source
- in_valid  input  1  qualifies inputs this cycle
- comb_out  output  32  combinational mux result, same cycle
- out  output  32  registered result
- out_valid  output  1  registered in_valid

Behaviour:
- Sign bit: sbit = ext AND imm[15], produced by the and-gate.
- Extension when lui=0: ext32 = {16{sbit}, imm}.
- Extension when lui=1: ext32 = {imm, 16'h0000`}; ext is ignored.
- Mux: comb_out = sel ? alt : ext32. Purely combinational, no latency.
- Register, on rising clk:
  - rst=1: out <= 32'h0000_0000 and out_valid <= 0.
  - Otherwise, if in_valid=1: out <= comb_out and out_valid <= 1.
  - Otherwise, if in_valid=0: out holds its previous value and out_valid <= 0.
- Latency: 1 cycle from inputs to out/out_valid.
- No back-pressure; a new input is accepted every cycle.
- Reset dominates in_valid in the same cycle.
- Reset mid-stream: the next edge clears both out and out_valid. The first valid input after rst deasserts appears one cycle later.
- Boundary: imm=16'h8000 with ext=1 gives 32'hFFFF_8000; with ext=0 it gives 32'h0000_8000.
- Boundary: imm=16'h7FFF gives 32'h0000_7FFF for either value of ext.
- No X propagation: every output is defined for all input combinations.
- comb_out is undefined only if inputs are X. It has no dependence on reset.

Optional Feature:
- Macro: IMM_SHIFT2_EN
- Defined:
  - Adds input port shift2 (1 bit), used for branch offsets.
  - When shift2=1 and lui=0: ext32 = {14{sbit}, imm, 2'b00}, i.e. an 18-bit value extended to 32 bits, with sbit = ext AND imm[15].
  - Priority: lui > shift2 > plain extension.
- Undefined: no shift2 port exists, and behaviour is identical to shift2=0.

Test Plan:
- rst=1 for 2 cycles with in_valid=1 and imm=16'h1234 -> out=32'h0, out_valid=0. Then rst=0 -> the next edge gives out=32'h0000_1234 and out_valid=1.
- imm=16'hFFFC, ext=1, sel=0 -> comb_out=32'hFFFF_FFFC immediately, out equal after 1 edge. Same with ext=0 -> 32'h0000_FFFC.
- lui=1, imm=16'hABCD, ext=1 -> out=32'hABCD_0000.
- sel=1, alt=32'h0040_0020, imm=16'h8000 -> out=32'h0040_0020. Then in_valid=0 for 3 cycles -> out holds 32'h0040_0020 and out_valid=0.
- With IMM_SHIFT2_EN: shift2=1, ext=1, imm=16'hFFFF -> 32'hFFFF_FFFC; imm=16'h0001 -> 32'h0000_0004.
- Back-to-back valid inputs 16'h0001, 16'h8001, 16'h7FFF with ext=1 -> out sequence 32'h0000_0001, 32'hFFFF_8001, 32'h0000_7FFF on consecutive cycles.
